// File: rtl/maxpool_stream.sv
// Streaming multi-channel WIN x WIN max-pool (stride WIN) over valid/ready; one row of partial maxima.
// Define MAXPOOL_SIGNED_EN for two's-complement (signed) element compare; default is unsigned.
module maxpool_stream #(
    parameter int unsigned IMG_W        = 26,
    parameter int unsigned IMG_H        = 26,
    parameter int unsigned WIN          = 13,
    parameter int unsigned ELEMENT_SIZE = 20,
    parameter int unsigned CHANNELS     = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [CHANNELS*ELEMENT_SIZE-1:0] i_data,
    input  logic                             i_valid,
    output logic                             i_ready,
    output logic [CHANNELS*ELEMENT_SIZE-1:0] o_data,
    output logic                             o_valid,
    input  logic                             o_ready,
    output logic                             o_last,
    output logic                             busy,
    output logic                             done
);
    localparam int unsigned OUT_W = IMG_W / WIN;
    localparam int unsigned OUT_H = IMG_H / WIN;
    localparam int unsigned CW    = CHANNELS * ELEMENT_SIZE;
    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned WIN_W = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int unsigned OC_W  = $clog2(OUT_W + 1);
    localparam int unsigned OR_W  = $clog2(OUT_H + 1);
    localparam int unsigned BI_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

    state_t            r_state;
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [WIN_W-1:0]  r_wc;
    logic [WIN_W-1:0]  r_wr;
    logic [OC_W-1:0]   r_oc;
    logic [OR_W-1:0]   r_orow;
    logic [CW-1:0]     r_o_data;
    logic              r_o_valid;
    logic              r_o_last;
    logic              r_busy;
    logic              r_done;
    logic [CW-1:0]     r_buf [OUT_W];

    logic              w_accept;
    logic              w_col_end;
    logic              w_row_end;
    logic              w_wc_end;
    logic              w_wr_end;
    logic              w_first;
    logic              w_emit;
    logic              w_in_grid;
    logic              w_last_win;
    logic [BI_W-1:0]   w_idx;
    logic [CW-1:0]     w_buf_rd;
    logic [CW-1:0]     w_max;

    // a > b in the configured number format
    function automatic logic gt(input logic [ELEMENT_SIZE-1:0] a, input logic [ELEMENT_SIZE-1:0] b);
`ifdef MAXPOOL_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

    assign i_ready    = (r_state == S_STREAM) && (!r_o_valid || o_ready);
    assign w_accept   = i_valid && i_ready;
    assign w_col_end  = (r_col == COL_W'(IMG_W - 1));
    assign w_row_end  = (r_row == ROW_W'(IMG_H - 1));
    assign w_wc_end   = (r_wc == WIN_W'(WIN - 1));
    assign w_wr_end   = (r_wr == WIN_W'(WIN - 1));
    assign w_first    = (r_wc == '0) && (r_wr == '0);
    assign w_emit     = w_wc_end && w_wr_end;
    assign w_in_grid  = (r_oc < OC_W'(OUT_W)) && (r_orow < OR_W'(OUT_H));
    assign w_last_win = (r_oc == OC_W'(OUT_W - 1)) && (r_orow == OR_W'(OUT_H - 1));
    assign w_idx      = BI_W'(r_oc);
    assign w_buf_rd   = r_buf[w_idx];

    assign o_data  = r_o_data;
    assign o_valid = r_o_valid;
    assign o_last  = r_o_last;
    assign busy    = r_busy;
    assign done    = r_done;

    // Per-channel max of the stored partial and the incoming pixel
    always_comb begin
        w_max = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            w_max[k*ELEMENT_SIZE +: ELEMENT_SIZE] =
                gt(i_data[k*ELEMENT_SIZE +: ELEMENT_SIZE], w_buf_rd[k*ELEMENT_SIZE +: ELEMENT_SIZE])
                ? i_data[k*ELEMENT_SIZE +: ELEMENT_SIZE] : w_buf_rd[k*ELEMENT_SIZE +: ELEMENT_SIZE];
        end
    end

    // Partial-max row; the first beat of a window loads, so no init is needed
    always_ff @(posedge clk) begin
        if (w_accept && w_in_grid && !w_emit) begin
            r_buf[w_idx] <= w_first ? i_data : w_max;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_col     <= '0;
            r_row     <= '0;
            r_wc      <= '0;
            r_wr      <= '0;
            r_oc      <= '0;
            r_orow    <= '0;
            r_o_data  <= '0;
            r_o_valid <= 1'b0;
            r_o_last  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_o_valid && o_ready) begin
                r_o_valid <= 1'b0;
                r_o_last  <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_STREAM;
                        r_busy  <= 1'b1;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_wc    <= '0;
                        r_wr    <= '0;
                        r_oc    <= '0;
                        r_orow  <= '0;
                    end
                end
                S_STREAM: begin
                    if (w_accept) begin
                        if (w_col_end) begin
                            r_col <= '0;
                            r_wc  <= '0;
                            r_oc  <= '0;
                            if (w_row_end) begin
                                r_row  <= '0;
                                r_wr   <= '0;
                                r_orow <= '0;
                            end else begin
                                r_row <= r_row + 1'b1;
                                if (w_wr_end) begin
                                    r_wr   <= '0;
                                    r_orow <= r_orow + 1'b1;
                                end else begin
                                    r_wr <= r_wr + 1'b1;
                                end
                            end
                        end else begin
                            r_col <= r_col + 1'b1;
                            if (w_wc_end) begin
                                r_wc <= '0;
                                r_oc <= r_oc + 1'b1;
                            end else begin
                                r_wc <= r_wc + 1'b1;
                            end
                        end
                        // Window complete: result goes straight to the output register
                        if (w_in_grid && w_emit) begin
                            r_o_data  <= w_first ? i_data : w_max;
                            r_o_valid <= 1'b1;
                            r_o_last  <= w_last_win;
                        end
                        if (w_col_end && w_row_end) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!r_o_valid || o_ready) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/maxpool_stream.md
Name: maxpool_stream

Overview:
- Streaming, multi-channel, parametrised max-pool stage for the CNN datapath; it sits between the convolution output and the dense/flatten stage.
- Accepts one pixel per beat in row-major order, all channels packed in one beat, over a valid/ready handshake.
- Emits one pooled pixel per non-overlapping WIN x WIN window, also over valid/ready.
- Keeps one row of partial maxima, so the full feature map is never held on a wide bus.

Parameters:
- IMG_W, 26, input width in pixels (>= WIN)
- IMG_H, 26, input height in pixels (>= WIN)
- WIN, 13, window side; stride = WIN
- ELEMENT_SIZE, 20, bits per channel element
- CHANNELS, 1, channels packed per beat
- Derived: OUT_W = IMG_W/WIN, OUT_H = IMG_H/WIN (floor). CW = CHANNELS*ELEMENT_SIZE.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; arms the block for one frame
- i_data  in  CW  input pixel; channel k at bits [k*ELEMENT_SIZE +: ELEMENT_SIZE]
- i_valid  in  1  input beat valid
- i_ready  out  1  block accepts the beat
- o_data  out  CW  pooled pixel, same channel packing as i_data
- o_valid  out  1  o_data valid
- o_ready  in  1  downstream accepts o_data
- o_last  out  1  qualifies the final pooled pixel of the frame
- busy  out  1  high in STREAM and DRAIN
- done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all counters 0; o_data=0; o_valid=0; o_last=0; done=0; busy=0; partial buffer contents don't-care.
- States and transitions:
  - IDLE: i_ready=0. start=1 -> STREAM.
  - STREAM: i_ready = !o_valid | o_ready. Beat accepted when i_valid & i_ready. After IMG_W*IMG_H accepted beats -> DRAIN.
  - DRAIN: i_ready=0. Wait until o_valid=0, or o_valid & o_ready -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
  - start outside IDLE: ignored.
- Counters per accepted beat:
  - col 0..IMG_W-1 wraps and increments row; row 0..IMG_H-1.
  - wc = col mod WIN, wr = row mod WIN, oc = col/WIN; kept as counters, no dividers.
- In-window beats (col < OUT_W*WIN and row < OUT_H*WIN), per channel:
  - wr=0 & wc=0: buf[oc] = pixel (load, no zero-init).
  - Otherwise: buf[oc] = max(buf[oc], pixel).
  - wr=WIN-1 & wc=WIN-1: o_data <= max(buf[oc], pixel) on the same edge; o_valid <= 1 next cycle; buf[oc] is not updated.
- Remainder beats (column or row outside the window grid): accepted and discarded, no output.
- Output register:
  - o_valid clears on o_valid & o_ready unless a new result loads on the same edge; simultaneous accept and load keeps o_valid=1 with the new data.
  - Latency: pooled pixel is valid the cycle after its window's last beat is accepted.
- o_last=1 with the output whose row/col are (OUT_H-1, OUT_W-1); otherwise 0.
- Outputs per frame: exactly OUT_W*OUT_H, in row-major order.
- Compare is per channel, independent; unsigned unless the optional feature is compiled in.
- Reset mid-frame: aborts immediately; any partial output is lost.
- i_valid while i_ready=0: no effect; the source must hold the beat.

Optional Feature:
- Macro: MAXPOOL_SIGNED_EN.
- Defined: elements are two's complement, compare is signed; a window of all negative values yields its (negative) maximum.
- Undefined: unsigned compare.
- The load-first-element rule makes both modes correct without a sentinel init value.

Test Plan:
- IMG 4x4, WIN 2, CH 1, pixels 0..15 row-major, o_ready=1 -> outputs 5, 7, 13, 15; o_last on 15; done 1 cycle after 15 is accepted.
- IMG 5x5, WIN 2, pixels 0..24 -> outputs 6, 8, 16, 18 (col 4 and row 4 dropped); done only after all 25 beats.
- CH 2, ELEMENT_SIZE 8, IMG 2x2, WIN 2, beats {ch1,ch0} = {1,9}, {7,2}, {3,3}, {0,8} -> o_data = {7,9}.
- 4x4 case with o_ready held low 10 cycles after first output -> i_ready=0, o_data stays 5, no beat lost, final sequence unchanged.
- MAXPOOL_SIGNED_EN, 2x2, values -5, -3, -8, -4 -> output -3 (0xFFFFD at width 20); without macro -> output 0xFFFFD as max unsigned of 0xFFFFB, 0xFFFFD, 0xFFFF8, 0xFFFFC.
- rst_n low mid-frame after 6 beats -> all outputs 0 immediately; new start plus full 4x4 frame -> 5, 7, 13, 15.
